mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Round-robin arbiter sharing one memory/resource port among three requesters (0: IF, 1: MEM, 2: debug/DMA).
//   Drives the 2-bit select of the datapath's 3:1 port mux and a one-hot grant back to requesters.
//   Holds a grant for a whole transaction until the resource signals completion.
//   Sits between pipeline request logic and the shared port mux in the CPU top level.
// PARAMETERS
//   MAX_HOLD   16   cycles a grant may last before forced release (used only with ARB_TIMEOUT_EN); must be >= 2
//   CNT_W      5    width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk_i      in   1   clock, all state on rising edge
//   rst_i      in   1   reset, asynchronous, active-low
//   req_i      in   3   request per requester, level, held until granted transaction ends
//   done_i     in   1   resource completed current transaction (1-cycle pulse, sampled only while busy_o=1)
//   grant_o    out  3   one-hot grant, registered; 3'b000 when idle
//   select_o   out  2   mux select = index of granted requester; only 0..2 ever driven
//   busy_o     out  1   1 while in GRANT state (equals |grant_o)
//   timeout_o  out  1   1-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//   Reset (rst_i=0, async): state=IDLE, grant_o=0, select_o=0, busy_o=0, timeout_o=0, last_q=2 (so req 0 wins first).
//   States: IDLE, GRANT. All outputs registered.
//   Priority: search order last_q+1, last_q+2, last_q (mod 3); first asserted req wins.
//   IDLE: any req_i set -> next cycle state=GRANT, grant_o=onehot(win), select_o=win. Latency req->grant = 1 cycle.
//   IDLE, no req: grant_o=0, select_o holds previous value (no glitching of mux select).
//   GRANT, done_i=1: last_q<=current; winner recomputed with updated priority using req_i excluding current;
//     winner exists -> direct handoff, new grant next cycle (zero bubble); none -> IDLE, grant_o=0.
//   GRANT, req_i[current] drops without done_i: treated as abort, same transition as done_i.
//   done_i and req drop same cycle: single release, no double advance of last_q.
//   done_i while IDLE: ignored.
//   Current requester re-asserting after release waits its round-robin turn; no starvation: any held req granted within 2 transactions.
//   Reset mid-transaction: grant drops asynchronously; transaction is lost, requester must re-request.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: hold counter cleared on each new grant, increments each GRANT cycle;
//     when count reaches MAX_HOLD-1 with no done_i -> release as for done_i (handoff rules apply),
//     timeout_o=1 for exactly the following cycle. done_i on that same cycle wins: normal release, no timeout_o.
//   ARB_TIMEOUT_EN undefined: no counter; timeout_o tied 0; grant held indefinitely until done_i or req drop.
// TESTING
//   Reset then req_i=3'b111 -> grant_o=001/select_o=0 at cycle+1; done pulses -> 010, then 100, then 001 (rotation).
//   req_i=3'b010 alone, done_i after 4 cycles -> grant 010 for 4 cycles, then IDLE grant 000, select_o stays 1.
//   Grant 001 with req_i=3'b101, done_i=1 -> next cycle grant_o=100 (no idle cycle between grants).
//   Grant 100, drop req_i[2] without done -> next cycle grant_o=000 or handoff, last_q=2.
//   rst_i low while grant_o=010 -> grant_o=000, select_o=0 immediately; after release req_i=3'b110 -> grant 010.
//   ARB_TIMEOUT_EN, MAX_HOLD=16, hold req 0, no done -> grant drops after 16 cycles, timeout_o one pulse; done on cycle 16 -> no pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port among IF, MEM and debug/DMA
// Optional forced release of over-long grants is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    input  logic       done_i,
    output logic [2:0] grant_o,
    output logic [1:0] select_o,
    output logic       busy_o,
    output logic       timeout_o
);
    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_grant;
    logic [2:0] w_grant_nx;
    logic [1:0] r_select;
    logic [1:0] w_select_nx;
    logic [1:0] r_last;
    logic [1:0] w_last_nx;
    logic       r_timeout;
    logic       w_timeout_nx;
    logic       w_new_grant;
    logic       w_hold_expired;
    logic       w_abort;
    logic       w_release;
    logic [2:0] w_cand;
    logic [1:0] w_base;
    logic [1:0] w_p1;
    logic [1:0] w_p2;
    logic       w_win_vld;
    logic [1:0] w_win;

    if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_params
        $error("mem_port_arbiter: MAX_HOLD must be >= 2 and fit in CNT_W bits");
    end

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // While granted the search starts after the current owner, who is excluded from the handoff.
    assign w_base = (r_state == S_GRANT) ? r_select : r_last;
    assign w_cand = (r_state == S_GRANT) ? (req_i & ~r_grant) : req_i;
    assign w_p1   = inc3(w_base);
    assign w_p2   = inc3(w_p1);

    always_comb begin
        w_win_vld = 1'b1;
        w_win     = w_base;
        if (w_cand[w_p1]) begin
            w_win = w_p1;
        end else if (w_cand[w_p2]) begin
            w_win = w_p2;
        end else if (!w_cand[w_base]) begin
            w_win_vld = 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold;

    assign w_hold_expired = (r_hold == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hold <= '0;
        end else if (w_new_grant) begin
            r_hold <= '0;
        end else if (r_state == S_GRANT) begin
            r_hold <= r_hold + CNT_W'(1);
        end
    end
`else
    assign w_hold_expired = 1'b0;
`endif

    assign w_abort   = ~|(req_i & r_grant);
    assign w_release = done_i | w_abort | w_hold_expired;

    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_select_nx  = r_select;
        w_last_nx    = r_last;
        w_timeout_nx = 1'b0;
        w_new_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_nx = 3'b000;
                if (w_win_vld) begin
                    w_state_nx  = S_GRANT;
                    w_grant_nx  = 3'b001 << w_win;
                    w_select_nx = w_win;
                    w_new_grant = 1'b1;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_last_nx    = r_select;
                    w_timeout_nx = w_hold_expired & ~done_i & ~w_abort;
                    if (w_win_vld) begin
                        w_grant_nx  = 3'b001 << w_win;
                        w_select_nx = w_win;
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_grant_nx = 3'b000;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_grant_nx = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_grant   <= 3'b000;
            r_select  <= 2'd0;
            r_last    <= 2'd2;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_select  <= w_select_nx;
            r_last    <= w_last_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign grant_o   = r_grant;
    assign select_o  = r_select;
    assign busy_o    = (r_state == S_GRANT);
    assign timeout_o = r_timeout;
endmodule
